// File: rtl/status_unit.sv
`default_nettype none
// ============================================================================
//  Module      : status_unit
//  Description : Architectural NZCV flag register with in-flight tracking of
//                flag-setting instructions between decode issue and execute
//                commit. Provides a combinational bypass of the committing
//                flags to the decode-stage condition checker.
//  Ports       : CLK          - rising-edge clock
//                RST          - asynchronous active-high reset
//                ISSUE_S      - decode issues an S=1 instruction this cycle
//                COMMIT_S     - execute writes flags this cycle
//                COMMIT_FLAGS - {N,Z,C,V} written when COMMIT_S=1
//                FLUSH        - squash all uncommitted flag-setters
//                STATUS       - registered {N,Z,C,V}
//                STATUS_FWD   - COMMIT_S ? COMMIT_FLAGS : STATUS
//                PENDING      - in-flight flag-setter count
//                FLAGS_BUSY   - flags not final even with the bypass
//                FULL         - PENDING == MAX_PENDING
//                ERR          - sticky protocol-error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module status_unit #(
    parameter int MAX_PENDING = 3,
    parameter int W           = $clog2(MAX_PENDING + 1)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ISSUE_S,
    input  logic         COMMIT_S,
    input  logic [3:0]   COMMIT_FLAGS,
    input  logic         FLUSH,
    output logic [3:0]   STATUS,
    output logic [3:0]   STATUS_FWD,
    output logic [W-1:0] PENDING,
    output logic         FLAGS_BUSY,
    output logic         FULL,
    output logic         ERR
);

    localparam logic [W-1:0] c_max_cnt  = W'(MAX_PENDING);
    localparam logic [W-1:0] c_zero_cnt = '0;

    logic [3:0]   status_q,  status_d;
    logic [W-1:0] pending_q, pending_d;
    logic         err_q,     err_d;

    logic         w_full;
    logic         w_empty;
    logic         w_issue_acc;
    logic         w_commit_cnt;
    logic         w_err_set;

    assign w_full  = (pending_q == c_max_cnt);
    assign w_empty = (pending_q == c_zero_cnt);

    // At full occupancy a new issue is only accepted when a commit frees a
    // slot in the same cycle, so the count can never exceed MAX_PENDING.
    assign w_issue_acc  = ISSUE_S & (~w_full | COMMIT_S);
    // A commit with nothing in flight is a protocol error and must not
    // decrement, so the counter never underflows.
    assign w_commit_cnt = COMMIT_S & ~w_empty;

    // Flush squashes the offending instruction, so neither case is an error
    // when it coincides with FLUSH.
    assign w_err_set = ~FLUSH & ((ISSUE_S & w_full & ~COMMIT_S) |
                                 (COMMIT_S & w_empty));

    always_comb begin
        status_d  = status_q;
        pending_d = pending_q;
        err_d     = err_q | w_err_set;

        // The committing instruction is older than any flush, so its flags
        // are always written.
        if (COMMIT_S) begin
            status_d = COMMIT_FLAGS;
        end

        if (FLUSH) begin
            pending_d = c_zero_cnt;
        end else begin
            pending_d = pending_q + W'(w_issue_acc) - W'(w_commit_cnt);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            status_q  <= 4'b0000;
            pending_q <= c_zero_cnt;
            err_q     <= 1'b0;
        end else begin
            status_q  <= status_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end

    assign STATUS     = status_q;
    assign STATUS_FWD = COMMIT_S ? COMMIT_FLAGS : status_q;
    assign PENDING    = pending_q;
    // A commit this cycle finalises exactly one outstanding setter; the
    // flags are only final if that was the last one.
    assign FLAGS_BUSY = (pending_q > W'(COMMIT_S));
    assign FULL       = w_full;
    assign ERR        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_status_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_status_unit
//  Description : Self-checking bench for status_unit. Directed scenarios plus
//                randomized traffic compared against a behavioural model of
//                flag state, in-flight count and sticky error.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_status_unit;

    localparam int MAX_PENDING = 3;
    localparam int W           = $clog2(MAX_PENDING + 1);

    logic         CLK;
    logic         RST;
    logic         ISSUE_S;
    logic         COMMIT_S;
    logic [3:0]   COMMIT_FLAGS;
    logic         FLUSH;
    logic [3:0]   STATUS;
    logic [3:0]   STATUS_FWD;
    logic [W-1:0] PENDING;
    logic         FLAGS_BUSY;
    logic         FULL;
    logic         ERR;

    int n_compared;
    int n_mismatched;

    // Behavioural model state
    int m_flags;
    int m_inflight;
    int m_err;

    status_unit #(.MAX_PENDING(MAX_PENDING)) u_dut (
        .CLK          (CLK),
        .RST          (RST),
        .ISSUE_S      (ISSUE_S),
        .COMMIT_S     (COMMIT_S),
        .COMMIT_FLAGS (COMMIT_FLAGS),
        .FLUSH        (FLUSH),
        .STATUS       (STATUS),
        .STATUS_FWD   (STATUS_FWD),
        .PENDING      (PENDING),
        .FLAGS_BUSY   (FLAGS_BUSY),
        .FULL         (FULL),
        .ERR          (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_model();
        int fwd;
        fwd = COMMIT_S ? int'(COMMIT_FLAGS) : m_flags;
        chk("status",  32'(STATUS),     32'(m_flags));
        chk("fwd",     32'(STATUS_FWD), 32'(fwd));
        chk("pending", 32'(PENDING),    32'(m_inflight));
        chk("busy",    32'(FLAGS_BUSY), 32'(m_inflight > int'(COMMIT_S)));
        chk("full",    32'(FULL),       32'(m_inflight == MAX_PENDING));
        chk("err",     32'(ERR),        32'(m_err));
    endtask

    // One clock cycle: drive at negedge, check pre-edge outputs, advance the
    // model at the rising edge, return at the next negedge.
    task automatic step(input logic iss, input logic com, input logic [3:0] fl, input logic flu);
        int slots_free;
        ISSUE_S      = iss;
        COMMIT_S     = com;
        COMMIT_FLAGS = fl;
        FLUSH        = flu;
        #1;
        chk_model();
        @(posedge CLK);
        if (com) m_flags = int'(fl);
        if (!flu && ((iss && !com && m_inflight == MAX_PENDING) || (com && m_inflight == 0)))
            m_err = 1;
        if (flu) begin
            m_inflight = 0;
        end else begin
            // Slots available to a new issue include the one a commit frees.
            slots_free = MAX_PENDING - m_inflight + ((com && m_inflight > 0) ? 1 : 0);
            if (com && m_inflight > 0) m_inflight = m_inflight - 1;
            if (iss && slots_free > 0 && (m_inflight < MAX_PENDING)) m_inflight = m_inflight + 1;
        end
        @(negedge CLK);
        ISSUE_S  = 1'b0;
        COMMIT_S = 1'b0;
        FLUSH    = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        m_flags    = 0;
        m_inflight = 0;
        m_err      = 0;
        chk_model();
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        m_flags      = 0;
        m_inflight   = 0;
        m_err        = 0;
        RST          = 1'b0;
        ISSUE_S      = 1'b0;
        COMMIT_S     = 1'b0;
        COMMIT_FLAGS = 4'b0000;
        FLUSH        = 1'b0;

        @(negedge CLK);
        do_reset();

        // Reset mid-run with two in flight, then a commit with nothing pending.
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("pend_2", 32'(PENDING), 32'd2);
        do_reset();
        chk("rst_status", 32'(STATUS), 32'd0);
        chk("rst_pend",   32'(PENDING), 32'd0);
        chk("rst_err",    32'(ERR), 32'd0);
        step(1'b0, 1'b1, 4'b0110, 1'b0);
        chk("plain_status", 32'(STATUS), 32'b0110);
        chk("plain_err",    32'(ERR), 32'd1);

        // Issue/commit pair
        do_reset();
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("pair_pend1", 32'(PENDING), 32'd1);
        chk("pair_busy1", 32'(FLAGS_BUSY), 32'd1);
        COMMIT_S = 1'b1; COMMIT_FLAGS = 4'b1000;
        #1;
        chk("pair_busy_c", 32'(FLAGS_BUSY), 32'd0);
        chk("pair_fwd_c",  32'(STATUS_FWD), 32'b1000);
        step(1'b0, 1'b1, 4'b1000, 1'b0);
        chk("pair_pend0",  32'(PENDING), 32'd0);
        chk("pair_status", 32'(STATUS), 32'b1000);
        chk("pair_err",    32'(ERR), 32'd0);

        // Fill to full
        do_reset();
        repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("fill_full", 32'(FULL), 32'd1);
        chk("fill_pend", 32'(PENDING), 32'd3);
        step(1'b1, 1'b1, 4'b0101, 1'b0);
        chk("full_ic_pend", 32'(PENDING), 32'd3);
        chk("full_ic_err",  32'(ERR), 32'd0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        chk("ovf_pend", 32'(PENDING), 32'd3);
        chk("ovf_err",  32'(ERR), 32'd1);
        step(1'b1, 1'b1, 4'b0011, 1'b0);
        chk("full_ic2_pend", 32'(PENDING), 32'd3);
        chk("full_ic2_err",  32'(ERR), 32'd1);

        // Flush with simultaneous issue and commit
        do_reset();
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b0, 4'h0, 1'b0);
        step(1'b1, 1'b1, 4'b0001, 1'b1);
        chk("flush_pend",   32'(PENDING), 32'd0);
        chk("flush_status", 32'(STATUS), 32'b0001);
        chk("flush_err",    32'(ERR), 32'd0);
        step(1'b0, 1'b1, 4'b1010, 1'b1);
        chk("flush_c0_err", 32'(ERR), 32'd0);

        // Bypass priority
        step(1'b0, 1'b1, 4'b1111, 1'b0);
        COMMIT_S = 1'b1; COMMIT_FLAGS = 4'b0000;
        #1;
        chk("byp_commit", 32'(STATUS_FWD), 32'b0000);
        COMMIT_S = 1'b0;
        #1;
        chk("byp_hold", 32'(STATUS_FWD), 32'b1111);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 4)
                do_reset();
            else
                step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
                     4'($urandom), $urandom_range(0, 99) < 5);
        end
        step(1'b0, 1'b0, 4'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
